dpram_pipe: RTL and testbench

DPRAM_PIPE -- requirements
Module: dpram_pipe

---
 rtl/dpram_pkg.sv | 13 +
 rtl/dpram_rd_pipe.sv | 54 +++++
 rtl/dpram_pipe.sv | 100 ++++++++++
 tb/tb_dpram_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the pipelined dual-port RAM (dpram_pipe).
package dpram_pkg;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;
  localparam int PARITY_MAX_W = 72;

  // Even parity: the returned bit makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-result latency stages: valid, data and parity-error flag travel together;
// data holds its last value whenever no fresh result moves into a stage.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr
);

  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    perr_q;
  logic [DATA_W-1:0] dat_q [LAT];

  // Error flag is qualified by valid at every stage so it is never seen without rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      perr_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid;
      perr_q[0] <= in_valid & in_perr;
      if (in_valid) begin
        dat_q[0] <= in_data;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        perr_q[i] <= vld_q[i-1] & perr_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_perr  = perr_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/dpram_pipe.sv
// Simple dual-port RAM with pipelined read and selectable collision policy.
// Optional per-word even parity is enabled by defining DPRAM_PIPE_PARITY_EN.
module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1,
  parameter int WR_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wen,
  input  logic              ren,
  input  logic              perr_inj,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DPRAM_PIPE_PARITY_EN
  localparam int STORE_W = DATA_W + 1;
`else
  localparam int STORE_W = DATA_W;
`endif

  logic [STORE_W-1:0] mem [DEPTH];
  logic [STORE_W-1:0] wr_word;
  logic [STORE_W-1:0] mem_word;
  logic [STORE_W-1:0] rd_word;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_perr;
  logic               collide;
  logic               mem_we;

`ifdef DPRAM_PIPE_PARITY_EN
  logic [PARITY_MAX_W-1:0] wr_ext;
  logic [PARITY_MAX_W-1:0] rd_ext;

  // Stored parity bit sits above the data; perr_inj flips it to fake a corrupted word.
  always_comb begin
    wr_ext                = '0;
    wr_ext[DATA_W-1:0]    = data_in;
    wr_word               = {even_parity(wr_ext) ^ perr_inj, data_in};
  end

  always_comb begin
    rd_data               = rd_word[DATA_W-1:0];
    rd_ext                = '0;
    rd_ext[DATA_W-1:0]    = rd_data;
    rd_perr               = even_parity(rd_ext) ^ rd_word[DATA_W];
  end
`else
  logic unused_perr_inj;

  assign unused_perr_inj = perr_inj;
  assign wr_word         = data_in;
  assign rd_data         = rd_word;
  assign rd_perr         = 1'b0;
`endif

  // Memory contents survive reset; only the write port is blocked while reset is held.
  assign mem_we = wen & rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= wr_word;
    end
  end

  assign mem_word = mem[raddr];
  assign collide  = wen && (waddr == raddr);

  // Write-first forwards the incoming word; read-first naturally sees the old content.
  always_comb begin
    rd_word = mem_word;
    if ((WR_FIRST != 0) && collide) begin
      rd_word = wr_word;
    end
  end

  dpram_rd_pipe #(
    .READ_LAT (READ_LAT),
    .DATA_W   (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ren),
    .in_data   (rd_data),
    .in_perr   (rd_perr),
    .out_valid (rvalid),
    .out_data  (data_out),
    .out_perr  (parity_err)
  );

endmodule

// File: tb/tb_dpram_pipe.sv
// Scoreboard bench for dpram_pipe: two instances (latency 1 write-first, latency 2 read-first)
// share one stimulus stream; a negedge monitor checks every result against queued expectations.
module tb_dpram_pipe;

`ifdef DPRAM_PIPE_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] waddr;
  logic [9:0] raddr;
  logic [7:0] data_in;
  logic       wen;
  logic       ren;
  logic       perr_inj;
  logic [7:0] dout_a;
  logic [7:0] dout_b;
  logic       rvalid_a;
  logic       rvalid_b;
  logic       perr_a;
  logic       perr_b;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] last_data [2];
  int         cyc      = 0;
  int         checks   = 0;
  int         failures = 0;
  logic       started  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dpram_pipe #(.DATA_W(8), .ADDR_W(10), .READ_LAT(1), .WR_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .raddr(raddr), .data_in(data_in),
    .wen(wen), .ren(ren), .perr_inj(perr_inj),
    .data_out(dout_a), .rvalid(rvalid_a), .parity_err(perr_a)
  );

  dpram_pipe #(.DATA_W(8), .ADDR_W(10), .READ_LAT(2), .WR_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .raddr(raddr), .data_in(data_in),
    .wen(wen), .ren(ren), .perr_inj(perr_inj),
    .data_out(dout_b), .rvalid(rvalid_b), .parity_err(perr_b)
  );

  task automatic compare(input string name, input int which, input logic [31:0] got,
                         input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", name, which, cyc, got, want);
    end
  endtask

  // One cycle of stimulus; a read pushes each instance's expected result and due cycle.
  task automatic applyStimulus(input logic w, input logic [9:0] wa, input logic [7:0] wd,
                               input logic inj, input logic r, input logic [9:0] ra,
                               input logic [7:0] exp_a, input logic [7:0] exp_b,
                               input logic exp_perr);
    exp_t e;
    @(negedge clk);
    wen      = w;
    waddr    = wa;
    data_in  = wd;
    perr_inj = inj;
    ren      = r;
    raddr    = ra;
    if (r) begin
      e.data = exp_a; e.perr = exp_perr; e.due = cyc + 1;
      q0.push_back(e);
      e.data = exp_b; e.perr = exp_perr; e.due = cyc + 2;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    end
  endtask

  task automatic checkReset(input string tag);
    compare({tag, "_data"},   0, 32'(dout_a),   32'h0);
    compare({tag, "_rvalid"}, 0, 32'(rvalid_a), 32'h0);
    compare({tag, "_perr"},   0, 32'(perr_a),   32'h0);
    compare({tag, "_data"},   1, 32'(dout_b),   32'h0);
    compare({tag, "_rvalid"}, 1, 32'(rvalid_b), 32'h0);
    compare({tag, "_perr"},   1, 32'(perr_b),   32'h0);
  endtask

  task automatic checkOutput(input int which, input logic v, input logic [7:0] d,
                             input logic p);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rvalid dut=%0d cyc=%0d got=%0h want=none", which, cyc, d);
      end else begin
        e = (which == 0) ? q0.pop_front() : q1.pop_front();
        compare("rd_data",    which, 32'(d),   32'(e.data));
        compare("rd_perr",    which, 32'(p),   32'(e.perr));
        compare("rd_latency", which, 32'(cyc), 32'(e.due));
        last_data[which] = e.data;
      end
    end else begin
      compare("hold_data", which, 32'(d), 32'(last_data[which]));
      compare("idle_perr", which, 32'(p), 32'h0);
      if (sz > 0) begin
        e = (which == 0) ? q0[0] : q1[0];
        if (e.due < cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL missing_rvalid dut=%0d cyc=%0d got=none want=%0h", which, cyc, e.data);
          if (which == 0) void'(q0.pop_front());
          else            void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && rst_n) begin
      checkOutput(0, rvalid_a, dout_a, perr_a);
      checkOutput(1, rvalid_b, dout_b, perr_b);
    end
  end

  // Reset pulled low the cycle after a read is issued: the latency-2 result is still in flight.
  task automatic resetMid();
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    #1 checkReset("mid_reset");
    applyStimulus(1'b1, 10'd7, 8'h99, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 10'd7, 8'h99, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    wen = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; wen = 1'b0; ren = 1'b0; perr_inj = 1'b0;
    waddr = '0; raddr = '0; data_in = '0;
    last_data[0] = 8'h00;
    last_data[1] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("por");
    #2 rst_n = 1'b1;
    started = 1'b1;

    // Basic write then read.
    applyStimulus(1'b1, 10'd3, 8'hA5, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd3, 8'hA5, 8'hA5, 1'b0);

    applyStimulus(1'b1, 10'd0, 8'h11, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 10'd1, 8'h22, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 10'd2, 8'h33, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 10'd5, 8'h0F, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 10'd7, 8'h77, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);

    // Back-to-back reads, first one alongside a write to an unrelated address.
    applyStimulus(1'b1, 10'd9, 8'h5A, 1'b0, 1'b1, 10'd0, 8'h11, 8'h11, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd1, 8'h22, 8'h22, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd2, 8'h33, 8'h33, 1'b0);
    idle(3);

    // Same-address collision: write-first sees new data, read-first sees old.
    applyStimulus(1'b1, 10'd5, 8'hF0, 1'b0, 1'b1, 10'd5, 8'hF0, 8'h0F, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd5, 8'hF0, 8'hF0, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd9, 8'h5A, 8'h5A, 1'b0);
    idle(3);

    // Read of address 7, then reset while the latency-2 result is in flight.
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd7, 8'h77, 8'h77, 1'b0);
    resetMid();
    idle(3);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd7, 8'h77, 8'h77, 1'b0);
    idle(3);

    // Parity injection and clean rewrite.
    applyStimulus(1'b1, 10'd4, 8'h3C, 1'b1, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd4, 8'h3C, 8'h3C, PAR_ON);
    applyStimulus(1'b1, 10'd4, 8'h3C, 1'b0, 1'b0, 10'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 10'd0, 8'h00, 1'b0, 1'b1, 10'd4, 8'h3C, 8'h3C, 1'b0);
    idle(4);

    compare("drain", 0, 32'(q0.size()), 32'h0);
    compare("drain", 1, 32'(q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
